branch_ctrl: RTL
================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter: SHADOW_CYCLES, default 3, number of non-stalled cycles after a redirect during which branch inputs are ignored; legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 m_ctlout  input  1  branch control bit from EX/MEM stage.
REQ-005 zero  input  1  ALU zero flag from EX/MEM stage.
REQ-006 add_result  input  32  branch target address from EX/MEM stage.
REQ-007 stall  input  1  pipeline stall; freezes controller sequencing.
REQ-008 PCSrc  output  1  registered PC mux select, 1 = take branch target.
REQ-009 pc_target  output  32  registered redirect address, valid when PCSrc=1.
REQ-010 flush  output  1  registered flush of IF/ID, ID/EX, EX/MEM; asserted with PCSrc.
REQ-011 shadow  output  1  high while in SHADOW state.

Function
REQ-012 Taken condition SHALL be m_ctlout && zero, evaluated only in IDLE with stall=0.
REQ-013 States SHALL be IDLE and SHADOW, encoded as 1 bit.
REQ-014 IDLE, taken condition in cycle N: cycle N+1 SHALL show PCSrc=1, flush=1, pc_target=add_result sampled at N, state=SHADOW, counter=SHADOW_CYCLES.
REQ-015 PCSrc and flush SHALL be high for exactly one cycle per accepted branch, regardless of stall.
REQ-016 IDLE with stall=1 SHALL accept no branch; the held EX/MEM inputs are re-evaluated on the first cycle stall=0.
REQ-017 SHADOW: m_ctlout/zero SHALL be ignored; each stall=0 cycle decrements counter; stall=1 holds counter.
REQ-018 SHADOW with counter=1 and stall=0 SHALL return to IDLE next cycle; the first branch accepted after return is evaluated in that IDLE cycle.
REQ-019 Counter SHALL be 3 bits, never wraps below 1 in SHADOW.
REQ-020 pc_target SHALL hold its last value when PCSrc=0.
REQ-021 Not-taken branch (m_ctlout=1, zero=0) SHALL produce no output change.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, counter=0, PCSrc=0, flush=0, shadow=0, pc_target=0.
REQ-023 rst SHALL take priority over every other input, including a simultaneous taken branch or mid-SHADOW state.

Configuration
REQ-024 Macro BRANCH_CTRL_STATS_EN SHALL, when defined, add outputs br_count[15:0] (accepted evaluations with m_ctlout=1 in IDLE, stall=0) and taken_count[15:0] (accepted redirects), both saturating at 0xFFFF, cleared by rst.
REQ-025 Without BRANCH_CTRL_STATS_EN the counters and ports SHALL not exist; all other behaviour identical.

Structure
REQ-026 Shared package mips_pkg SHALL hold the state typedef (IDLE/SHADOW), address width constant (32), and default SHADOW_CYCLES.
REQ-027 Taken logic SHALL be instantiated from the existing MEM-stage branch AND gate sub-module (AND_Gate) rather than re-coded.
REQ-028 No other sub-modules; stats counters inline under the macro.

Verification
REQ-029 Reset: rst=1 two cycles with m_ctlout=1, zero=1 -> PCSrc=0, flush=0, shadow=0, pc_target=0 throughout.
REQ-030 Single branch: IDLE, m_ctlout=1, zero=1, add_result=0x0040_0020 at cycle 5 -> cycle 6 PCSrc=1, flush=1, pc_target=0x0040_0020; shadow=1 cycles 6-8; IDLE at cycle 9.
REQ-031 Shadow suppression: second taken branch, add_result=0x0000_1000, at cycles 7 and 8 -> no PCSrc, pc_target stays 0x0040_0020.
REQ-032 Stall: taken branch with stall=1 cycles 3-4, stall=0 cycle 5 -> PCSrc=1 only at cycle 6; stall=1 during SHADOW for 2 cycles extends shadow by 2.
REQ-033 Reset mid-SHADOW: rst at counter=2 -> next cycle IDLE, shadow=0; taken branch following cycle redirects normally.
REQ-034 With BRANCH_CTRL_STATS_EN: 3 not-taken + 2 taken (separated past shadow) -> br_count=5, taken_count=2; preload to 0xFFFF and branch -> stays 0xFFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: redirect controller state encoding,
// address width and the default shadow length.
package mips_pkg;

    localparam int unsigned ADDR_W            = 32;
    localparam int unsigned SHADOW_CYCLES_DEF = 3;

    typedef logic [0:0] br_state_t;

    localparam br_state_t IDLE   = 1'b0;
    localparam br_state_t SHADOW = 1'b1;

endpackage

// File: rtl/branch_ctrl_and_gate.sv
// MEM-stage branch AND gate: a branch is taken when the control bit and the
// ALU zero flag are both set.
module AND_Gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = a_i & b_i;

endmodule

// File: rtl/branch_ctrl.sv
// Branch redirect controller: one-cycle PC redirect/flush, then a shadow window
// that ignores branch inputs. Optional counters under BRANCH_CTRL_STATS_EN.
module branch_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned SHADOW_CYCLES = SHADOW_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_ctlout,
    input  logic              zero,
    input  logic [ADDR_W-1:0] add_result,
    input  logic              stall,
`ifdef BRANCH_CTRL_STATS_EN
    output logic [15:0]       br_count,
    output logic [15:0]       taken_count,
`endif
    output logic              PCSrc,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic              shadow
);

    localparam logic [2:0] SHADOW_LOAD = 3'(SHADOW_CYCLES);

    logic              taken;
    br_state_t         state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              redirect_q, redirect_d;
    logic [ADDR_W-1:0] target_q, target_d;

    AND_Gate u_and_gate (
        .a_i (m_ctlout),
        .b_i (zero),
        .y_o (taken)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        redirect_d = 1'b0;
        target_d   = target_q;
        case (state_q)
            IDLE: begin
                if (!stall && taken) begin
                    state_d    = SHADOW;
                    cnt_d      = SHADOW_LOAD;
                    redirect_d = 1'b1;
                    target_d   = add_result;
                end
            end
            SHADOW: begin
                // Counter only advances on non-stalled cycles; never goes below 1 here.
                if (!stall) begin
                    if (cnt_q <= 3'd1) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            redirect_q <= 1'b0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
        end
    end

    assign PCSrc     = redirect_q;
    assign flush     = redirect_q;
    assign pc_target = target_q;
    assign shadow    = (state_q == SHADOW);

`ifdef BRANCH_CTRL_STATS_EN
    logic [15:0] br_cnt_q, br_cnt_d;
    logic [15:0] tk_cnt_q, tk_cnt_d;

    always_comb begin
        br_cnt_d = br_cnt_q;
        tk_cnt_d = tk_cnt_q;
        if (state_q == IDLE && !stall && m_ctlout && br_cnt_q != 16'hFFFF)
            br_cnt_d = br_cnt_q + 16'd1;
        if (redirect_d && tk_cnt_q != 16'hFFFF)
            tk_cnt_d = tk_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q <= 16'd0;
            tk_cnt_q <= 16'd0;
        end else begin
            br_cnt_q <= br_cnt_d;
            tk_cnt_q <= tk_cnt_d;
        end
    end

    assign br_count    = br_cnt_q;
    assign taken_count = tk_cnt_q;
`endif

endmodule
